locked_result_scoreboard: RTL and testbench

LOCKED_RESULT_SCOREBOARD -- requirements
Module: locked_result_scoreboard

---
 rtl/locked_result_scoreboard_if.sv | 21 ++
 rtl/locked_result_scoreboard.sv | 126 ++++++++++++
 tb/tb_locked_result_scoreboard.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/locked_result_scoreboard_if.sv
// Result-pair stream into the locked-adder scoreboard: one pair of adder
// results per valid/ready handshake, with vec_last marking the final pair.
interface locked_result_scoreboard_if #(
    parameter int WIDTH = 33
);
    logic             vec_valid;
    logic             vec_ready;
    logic             vec_last;
    logic [WIDTH-1:0] result_locked;
    logic [WIDTH-1:0] result_golden;

    modport master (
        output vec_valid, vec_last, result_locked, result_golden,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_last, result_locked, result_golden,
        output vec_ready
    );
endinterface

// File: rtl/locked_result_scoreboard.sv
// Scores a logic-locking key trial: counts result pairs, mismatching pairs and total Hamming distance.
// Optional max_hd output (largest per-pair Hamming distance) enabled by defining LOCKED_SCORE_MAX_HD_EN.
module locked_result_scoreboard #(
    parameter int WIDTH = 33,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           trial_start,
    locked_result_scoreboard_if.slave      vec,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               vec_count,
    output logic [CNT_W-1:0]               mismatch_count,
    output logic [ACC_W-1:0]               hd_sum
`ifdef LOCKED_SCORE_MAX_HD_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0]     max_hd
`endif
);

    localparam int PC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic             ready;
    logic             handshake;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_diff;
    logic [PC_W-1:0]  s1_pop;
    logic [ACC_W:0]   hd_sum_ext;

    assign vec.vec_ready = ready;
    assign handshake     = vec.vec_valid & ready;
    assign hd_sum_ext    = {1'b0, hd_sum} + (ACC_W+1)'(s1_pop);

    always_comb begin
        // NOTE: default assignment before the loop keeps this purely combinational (no latch).
        s1_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_pop = s1_pop + PC_W'(s1_diff[i]);
        end
    end

    // NOTE: pure datapath register qualified by s1_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (handshake) begin
            s1_diff <= vec.result_locked ^ vec.result_golden;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ready          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            s1_valid       <= 1'b0;
            vec_count      <= '0;
            mismatch_count <= '0;
            hd_sum         <= '0;
`ifdef LOCKED_SCORE_MAX_HD_EN
            max_hd         <= '0;
`endif
        end else begin
            s1_valid <= handshake;

            // Stage 2: fold the registered difference into the saturating totals.
            if (s1_valid) begin
                if (vec_count != '1) begin
                    vec_count <= vec_count + CNT_W'(1);
                end
                if (s1_diff != '0 && mismatch_count != '1) begin
                    mismatch_count <= mismatch_count + CNT_W'(1);
                end
                hd_sum <= hd_sum_ext[ACC_W] ? '1 : hd_sum_ext[ACC_W-1:0];
`ifdef LOCKED_SCORE_MAX_HD_EN
                if (s1_pop > max_hd) begin
                    max_hd <= s1_pop;
                end
`endif
            end

            case (state)
                IDLE, DONE: begin
                    if (trial_start) begin
                        state          <= RUN;
                        ready          <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        s1_valid       <= 1'b0;
                        vec_count      <= '0;
                        mismatch_count <= '0;
                        hd_sum         <= '0;
`ifdef LOCKED_SCORE_MAX_HD_EN
                        max_hd         <= '0;
`endif
                    end
                end
                RUN: begin
                    if (handshake && vec.vec_last) begin
                        state <= DRAIN;
                        ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Only the final pair can be in stage 1 here; it is absorbed at this edge.
                    if (s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_locked_result_scoreboard.sv
// Self-checking bench: trial-level reference model compared every cycle against a default DUT
// and a narrow-counter DUT (saturation), plus literal expectations for the directed cases.
module tb_locked_result_scoreboard;

    localparam int WIDTH   = 33;
    localparam int CNT_W   = 16;
    localparam int ACC_W   = 24;
    localparam int S_CNT_W = 4;
    localparam int S_ACC_W = 6;
    localparam int PC_W    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst         = 1'b0;
    logic trial_start = 1'b0;

    locked_result_scoreboard_if #(.WIDTH(WIDTH)) bus ();
    locked_result_scoreboard_if #(.WIDTH(WIDTH)) sat_bus ();

    assign sat_bus.vec_valid     = bus.vec_valid;
    assign sat_bus.vec_last      = bus.vec_last;
    assign sat_bus.result_locked = bus.result_locked;
    assign sat_bus.result_golden = bus.result_golden;

    logic               busy, done, s_busy, s_done;
    logic [CNT_W-1:0]   vec_count, mismatch_count;
    logic [ACC_W-1:0]   hd_sum;
    logic [S_CNT_W-1:0] s_vec_count, s_mismatch_count;
    logic [S_ACC_W-1:0] s_hd_sum;
`ifdef LOCKED_SCORE_MAX_HD_EN
    logic [PC_W-1:0]    max_hd, s_max_hd;
`endif

    locked_result_scoreboard #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .trial_start(trial_start), .vec(bus),
        .busy(busy), .done(done), .vec_count(vec_count),
        .mismatch_count(mismatch_count), .hd_sum(hd_sum)
`ifdef LOCKED_SCORE_MAX_HD_EN
        , .max_hd(max_hd)
`endif
    );

    locked_result_scoreboard #(.WIDTH(WIDTH), .CNT_W(S_CNT_W), .ACC_W(S_ACC_W)) dut_sat (
        .clk(clk), .rst(rst), .trial_start(trial_start), .vec(sat_bus),
        .busy(s_busy), .done(s_done), .vec_count(s_vec_count),
        .mismatch_count(s_mismatch_count), .hd_sum(s_hd_sum)
`ifdef LOCKED_SCORE_MAX_HD_EN
        , .max_hd(s_max_hd)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model: trial-level bookkeeping ----------------
    bit     armed = 0;
    bit     m_in_trial, m_last_taken, m_pend;
    int     m_since, m_pend_pc, m_max;
    longint m_vc, m_mc, m_hd;

    function automatic longint sat(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic bit m_done();
        return m_last_taken && (m_since >= 2);
    endfunction

    task automatic m_clear();
        m_vc = 0; m_mc = 0; m_hd = 0; m_max = 0; m_pend = 0; m_pend_pc = 0;
    endtask

    always @(posedge clk) begin : model
        bit pre_ready, pre_done, hs;
        if (rst) begin
            m_clear();
            m_in_trial = 0; m_last_taken = 0; m_since = 0;
            armed = 1;
        end else if (armed) begin
            pre_done  = m_done();
            pre_ready = m_in_trial && !m_last_taken;
            hs        = bus.vec_valid && pre_ready;
            if (m_pend) begin
                m_vc++;
                if (m_pend_pc != 0) m_mc++;
                m_hd += m_pend_pc;
                if (m_pend_pc > m_max) m_max = m_pend_pc;
            end
            m_pend = hs;
            if (hs) m_pend_pc = $countones(bus.result_locked ^ bus.result_golden);
            if (m_last_taken) m_since++;
            if (hs && bus.vec_last) begin
                m_last_taken = 1; m_since = 1;
            end
            if (trial_start && (!m_in_trial || pre_done)) begin
                m_clear();
                m_in_trial = 1; m_last_taken = 0; m_since = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (armed) begin
            check("ready",      bus.vec_ready,    m_in_trial && !m_last_taken);
            check("busy",       busy,             m_in_trial && !m_done());
            check("done",       done,             m_done());
            check("vec_count",  vec_count,        sat(m_vc, CNT_W));
            check("mismatch",   mismatch_count,   sat(m_mc, CNT_W));
            check("hd_sum",     hd_sum,           sat(m_hd, ACC_W));
            check("s_ready",    sat_bus.vec_ready, m_in_trial && !m_last_taken);
            check("s_done",     s_done,           m_done());
            check("s_busy",     s_busy,           m_in_trial && !m_done());
            check("s_vec_count", s_vec_count,     sat(m_vc, S_CNT_W));
            check("s_mismatch", s_mismatch_count, sat(m_mc, S_CNT_W));
            check("s_hd_sum",   s_hd_sum,         sat(m_hd, S_ACC_W));
`ifdef LOCKED_SCORE_MAX_HD_EN
            check("max_hd",     max_hd,           m_max);
            check("s_max_hd",   s_max_hd,         m_max);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic start_trial();
        trial_start = 1'b1;
        tick(1);
        trial_start = 1'b0;
    endtask

    task automatic send_pair(input logic [WIDTH-1:0] locked, input logic [WIDTH-1:0] golden, input bit last);
        bit taken = 0;
        bus.vec_valid     = 1'b1;
        bus.vec_last      = last;
        bus.result_locked = locked;
        bus.result_golden = golden;
        for (int i = 0; i < 50 && !taken; i++) begin
            if (bus.vec_ready) taken = 1;
            tick(1);
        end
        if (!taken) check("handshake_timeout", 0, 1);
        bus.vec_valid = 1'b0;
        bus.vec_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1;
            else tick(1);
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        w = {$urandom_range(0, 1) == 1, $urandom()};
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] rand_diff();
        logic [WIDTH-1:0] d;
        case ($urandom_range(0, 3))
            0:       d = '0;
            1:       d = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            2:       d = rand_word();
            default: d = '1;
        endcase
        return d;
    endfunction

    initial begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] diffs [3];
        bus.vec_valid = 1'b0; bus.vec_last = 1'b0;
        bus.result_locked = '0; bus.result_golden = '0;
        tick(2);
        do_reset();

        // Reset state
        check("rst_ready", bus.vec_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec_count", vec_count, 0);
        check("rst_hd_sum", hd_sum, 0);

        // Correct key: 10 matching pairs, done exactly two cycles after the last handshake
        start_trial();
        for (int k = 0; k < 10; k++) begin
            g = rand_word();
            send_pair(g, g, k == 9);
        end
        check("ck_done_early", done, 0);
        tick(1);
        check("ck_done_on_time", done, 1);
        check("ck_vec_count", vec_count, 10);
        check("ck_mismatch", mismatch_count, 0);
        check("ck_hd_sum", hd_sum, 0);

        // One-bit corruption on every pair
        start_trial();
        for (int k = 0; k < 4; k++) begin
            g = rand_word();
            send_pair(g ^ 33'h0_0000_0010, g, k == 3);
        end
        wait_done();
        check("ob_vec_count", vec_count, 4);
        check("ob_mismatch", mismatch_count, 4);
        check("ob_hd_sum", hd_sum, 4);
`ifdef LOCKED_SCORE_MAX_HD_EN
        check("ob_max_hd", max_hd, 1);
`endif

        // Mixed differences
        diffs[0] = 33'h0; diffs[1] = 33'h1_FFFF_FFFF; diffs[2] = 33'h3;
        start_trial();
        for (int k = 0; k < 3; k++) begin
            g = rand_word();
            send_pair(g ^ diffs[k], g, k == 2);
        end
        wait_done();
        check("mx_vec_count", vec_count, 3);
        check("mx_mismatch", mismatch_count, 2);
        check("mx_hd_sum", hd_sum, 35);
`ifdef LOCKED_SCORE_MAX_HD_EN
        check("mx_max_hd", max_hd, 33);
`endif

        // vec_valid held through DRAIN and DONE is ignored; start+valid in DONE clears
        start_trial();
        for (int k = 0; k < 3; k++) begin
            g = rand_word();
            send_pair(g ^ 33'h5, g, k == 2);
        end
        bus.vec_valid = 1'b1;
        bus.result_locked = '1; bus.result_golden = '0;
        tick(6);
        check("bp_vec_count", vec_count, 3);
        check("bp_ready", bus.vec_ready, 0);
        trial_start = 1'b1;
        tick(1);
        trial_start = 1'b0;
        bus.vec_valid = 1'b0;
        tick(2);
        check("bp_clear_wins", vec_count, 0);
        send_pair('0, '0, 1'b1);
        wait_done();
        check("bp_single", vec_count, 1);

        // Saturation on the narrow-counter instance
        start_trial();
        for (int k = 0; k < 20; k++) begin
            g = rand_word();
            send_pair(~g, g, k == 19);
        end
        wait_done();
        check("sat_main_vec_count", vec_count, 20);
        check("sat_vec_count", s_vec_count, 15);
        check("sat_mismatch", s_mismatch_count, 15);
        check("sat_hd_sum", s_hd_sum, 63);

        // Reset mid-trial discards everything; a fresh trial counts from zero
        start_trial();
        for (int k = 0; k < 5; k++) begin
            g = rand_word();
            send_pair(g ^ 33'h1, g, 1'b0);
        end
        do_reset();
        check("mr_vec_count", vec_count, 0);
        check("mr_hd_sum", hd_sum, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        start_trial();
        for (int k = 0; k < 2; k++) begin
            g = rand_word();
            send_pair(g, g, k == 1);
        end
        wait_done();
        check("mr_new_count", vec_count, 2);

        // Randomized trials with gaps, ignored trial_start / vec_valid noise and occasional resets
        for (int t = 0; t < 40; t++) begin
            int n, abort_at;
            bus.vec_valid = $urandom_range(0, 1) == 1;
            bus.result_locked = rand_word(); bus.result_golden = rand_word();
            start_trial();
            bus.vec_valid = 1'b0;
            n = $urandom_range(1, 12);
            abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int j = 0; j < gap; j++) begin
                    trial_start = $urandom_range(0, 3) == 0;
                    tick(1);
                end
                trial_start = 1'b0;
                if (k == abort_at) begin
                    do_reset();
                    break;
                end
                g = rand_word();
                send_pair(g ^ rand_diff(), g, k == n - 1);
            end
            if (abort_at < 0) wait_done();
            bus.vec_valid = $urandom_range(0, 1) == 1;
            bus.result_locked = rand_word();
            tick($urandom_range(1, 3));
            bus.vec_valid = 1'b0;
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
